shot_logic: RTL and testbench

- Projectile generator for the player's gun. It is the originating end of the shot/target collision interface that the bird targets consume.
- Launches one shot from the player's position on a fire request and moves it upward once per frame in fixed-point.
- Reports a hit when the collision detector flags the shot, then enforces a reload cooldown.
- Sits beside the bird objects; its coordinate feeds the shot drawer and the collision detector.

---
 rtl/shot_logic.sv | 133 +++++++++++++
 tb/tb_shot_logic.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/shot_logic.sv
// Player shot generator: launches a shot from the player's position on a fire edge,
// moves it upward each frame in 1/64-pixel fixed point, and reports hits followed by a reload cooldown.
module shot_logic #(
  parameter int INITIAL_Y       = 400,
  parameter int PLAYER_WIDTH    = 32,
  parameter int SHOT_WIDTH      = 4,
  parameter int BASE_STEP       = 256,
  parameter int SPEED_STEP      = 64,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic                     fire,
  input  logic signed [10:0]       player_x,
  input  logic                     collision,
  input  logic        [1:0]        speed,
  output logic                     active,
  output logic                     hit,
  output logic signed [1:0][10:0]  coordinate
);

  // state    | meaning
  // IDLE     | waiting for a fire edge; shot not drawn
  // FLYING   | shot in flight, moving up once per frame
  // COOLDOWN | shot consumed or left screen; reload delay running

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  localparam int                 CW     = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic        [16:0] Y_INIT = 17'(INITIAL_Y * 64);
  localparam logic signed [12:0] X_OFS  = 13'(PLAYER_WIDTH / 2 - SHOT_WIDTH / 2);
  localparam logic signed [12:0] X_MAX  = 13'(639 - SHOT_WIDTH);

  state_t            r_state;
  state_t            w_next;
  logic              r_fire_d;
  logic              r_hit;
  logic [CW-1:0]     r_cnt;
  logic [16:0]       r_x;
  logic [16:0]       r_y;

  logic              w_fire_edge;
  logic [16:0]       w_step;
  logic signed [12:0] w_cx;
  logic [16:0]       w_launch_x;
  logic              w_top_exit;

  assign w_fire_edge = fire && !r_fire_d;
  assign w_step      = 17'(BASE_STEP + SPEED_STEP * int'(speed));
  assign w_cx        = $signed({{2{player_x[10]}}, player_x}) + X_OFS;
  assign w_top_exit  = startOfFrame && (r_y < w_step);

  always_comb begin
    w_launch_x = '0;
    if (w_cx < 0)
      w_launch_x = '0;
    else if (w_cx > X_MAX)
      w_launch_x = {X_MAX[10:0], 6'd0};
    else
      w_launch_x = {w_cx[10:0], 6'd0};
  end

  // state register
  always_ff @(posedge clk) begin
    if (!resetN)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_fire_edge) w_next = FLYING;
      FLYING: begin
        // a collision wins over a same-cycle frame tick
        if (collision)       w_next = COOLDOWN;
        else if (w_top_exit) w_next = COOLDOWN;
      end
      COOLDOWN: if (startOfFrame && r_cnt <= CW'(1)) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // output decode
  always_comb begin
    active = 1'b0;
    if (r_state == FLYING) active = 1'b1;
  end

  assign hit        = r_hit;
  assign coordinate = {r_y[16:6], r_x[16:6]};

  // datapath: edge detect, position, cooldown counter, hit pulse
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_fire_d <= 1'b0;
      r_hit    <= 1'b0;
      r_cnt    <= '0;
      r_x      <= '0;
      r_y      <= Y_INIT;
    end else begin
      r_fire_d <= fire;
      r_hit    <= (r_state == FLYING) && collision;
      case (r_state)
        IDLE: begin
          if (w_fire_edge) begin
            r_x <= w_launch_x;
            r_y <= Y_INIT;
          end
        end
        FLYING: begin
          if (collision || w_top_exit)
            r_cnt <= CW'(COOLDOWN_FRAMES);
          else if (startOfFrame)
            r_y <= r_y - w_step;
        end
        COOLDOWN: begin
          if (startOfFrame && r_cnt != '0)
            r_cnt <= r_cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shot_logic.sv
// Directed bench for shot_logic: launch, flight, top exit, hits, cooldown,
// fire-edge filtering, X clamping and mid-flight reset.
module tb_shot_logic;

  logic                    clk;
  logic                    resetN;
  logic                    startOfFrame;
  logic                    fire;
  logic signed [10:0]      player_x;
  logic                    collision;
  logic [1:0]              speed;
  logic                    active;
  logic                    hit;
  logic signed [1:0][10:0] coordinate;

  int n_assert = 0;
  int n_fail   = 0;

  shot_logic dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .fire         (fire),
    .player_x     (player_x),
    .collision    (collision),
    .speed        (speed),
    .active       (active),
    .hit          (hit),
    .coordinate   (coordinate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic launch(input logic signed [10:0] px);
    player_x = px;
    fire = 1'b0;
    tick();
    fire = 1'b1;
    tick();
    fire = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; fire = 1'b0;
    player_x = '0; collision = 1'b0; speed = 2'd0;
    tick(); tick();
    resetN = 1'b1;
    check("reset_active", 32'(active), 0);
    check("reset_hit",    32'(hit), 0);
    check("reset_x",      32'(coordinate[0]), 0);
    check("reset_y",      32'(coordinate[1]), 400);

    // shot 1: centred launch, straight flight off the top
    launch(11'sd100);
    check("launch_active", 32'(active), 1);
    check("launch_x",      32'(coordinate[0]), 114);
    check("launch_y",      32'(coordinate[1]), 400);
    frame();
    check("frame1_y", 32'(coordinate[1]), 396);
    frames(99);
    check("frame100_y",      32'(coordinate[1]), 0);
    check("frame100_active", 32'(active), 1);
    frame();
    check("exit_active", 32'(active), 0);
    check("exit_hit",    32'(hit), 0);
    check("exit_y",      32'(coordinate[1]), 0);

    // edge in cooldown, then fire held high across IDLE entry
    fire = 1'b1;
    tick();
    check("cool_fire_ignored", 32'(active), 0);
    frames(8);
    tick(); tick();
    check("held_fire_no_launch", 32'(active), 0);

    // shot 2: clamped left, fast speed, collision with frame tick
    speed = 2'd3;
    launch(-11'sd20);
    check("clamp_left_x",  32'(coordinate[0]), 0);
    check("clamp_left_on", 32'(active), 1);
    frame();
    check("fast_y1", 32'(coordinate[1]), 393);
    frame();
    check("fast_y2", 32'(coordinate[1]), 386);

    // fire edge during flight must not relaunch
    fire = 1'b1; tick(); fire = 1'b0; tick();
    check("fly_fire_y", 32'(coordinate[1]), 386);

    speed = 2'd0;
    collision = 1'b1; startOfFrame = 1'b1;
    tick();
    collision = 1'b0; startOfFrame = 1'b0;
    check("hit2_pulse",  32'(hit), 1);
    check("hit2_active", 32'(active), 0);
    check("hit2_y",      32'(coordinate[1]), 386);
    tick();
    check("hit2_pulse_end", 32'(hit), 0);

    // collision in cooldown ignored; 7 frames is not enough to reload
    collision = 1'b1;
    tick();
    collision = 1'b0;
    tick();
    check("cool_collision_nohit", 32'(hit), 0);
    frames(7);
    launch(11'sd630);
    check("cool7_no_launch", 32'(active), 0);
    frame();

    // shot 3: clamped right, hit at Y=300 with simultaneous frame
    launch(11'sd630);
    check("clamp_right_x",  32'(coordinate[0]), 635);
    check("clamp_right_on", 32'(active), 1);
    frames(25);
    check("y300", 32'(coordinate[1]), 300);
    collision = 1'b1; startOfFrame = 1'b1;
    tick();
    collision = 1'b0; startOfFrame = 1'b0;
    check("hit3_pulse",  32'(hit), 1);
    check("hit3_active", 32'(active), 0);
    check("hit3_y",      32'(coordinate[1]), 300);
    check("hit3_x",      32'(coordinate[0]), 635);
    tick();
    check("hit3_pulse_end", 32'(hit), 0);
    frames(8);

    // shot 4: reset mid-flight at Y=200
    launch(11'sd200);
    check("shot4_x", 32'(coordinate[0]), 214);
    frames(50);
    check("shot4_y200", 32'(coordinate[1]), 200);
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    check("rst_active", 32'(active), 0);
    check("rst_hit",    32'(hit), 0);
    check("rst_x",      32'(coordinate[0]), 0);
    check("rst_y",      32'(coordinate[1]), 400);

    // immediately idle after reset: a launch succeeds without cooldown
    launch(11'sd10);
    check("post_rst_launch", 32'(active), 1);
    check("post_rst_x",      32'(coordinate[0]), 24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
